mcm_collect: RTL and testbench

Front-end stage of the MCM path. On each frame request from the outer driver it pulses a request to the MCM link and collects the returned byte stream into the 8-bit MCM RAM. It then raises `oDone`, which starts the MCM packer reading that RAM. If the link stalls, a gap timeout zero-pads the frame so the packer always receives a complete frame.

---
 rtl/mcm_pkg.sv | 16 +
 rtl/sync_rise.sv | 22 ++
 rtl/mcm_collect.sv | 112 +++++++++++
 tb/tb_mcm_collect.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcm_pkg.sv
// Shared MCM constants and the collector state encoding.
// Imported by the collector and the packer.
package mcm_pkg;

  localparam int MCM_NBYTES  = 144;
  localparam int MCM_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RECV = 3'd2,
    PAD  = 3'd3,
    DONE = 3'd4
  } mcmState_t;

endpackage

// File: rtl/sync_rise.sv
// 3-FF synchroniser with a one-cycle edge detector.
// Ports: clk, reset (async low), iLevel async in, oPulse edge out.
module sync_rise #(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic iLevel,
  output logic oPulse
);

  logic [2:0] sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 3'b000;
    else        sync <= {sync[1:0], iLevel};
  end

  assign oPulse = RISE ? (sync[1] & ~sync[2])
                       : (~sync[1] & sync[2]);

endmodule

// File: rtl/mcm_collect.sv
// Collects one MCM frame into the MCM RAM, zero-padding on timeout.
// Ports: clk, reset, iStart, iByte/iByteValid -> oReq, oWr*, oDone, oErr.
module mcm_collect
  import mcm_pkg::*;
#(
  parameter int NBYTES  = MCM_NBYTES,
  parameter int TIMEOUT = MCM_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iStart,
  input  logic [7:0] iByte,
  input  logic       iByteValid,
  output logic       oReq,
  output logic [7:0] oWrAddr,
  output logic [7:0] oWrData,
  output logic       oWren,
  output logic       oDone,
  output logic       oErr
);

  localparam int TW = $clog2(TIMEOUT);

  mcmState_t   state;
  mcmState_t   stateNext;
  logic [7:0]  cnt;
  logic [TW-1:0] timer;
  logic        startRise;
  logic        lastAddr;
  logic        timeUp;

  sync_rise #(.RISE(1'b1)) uSync (
    .clk    (clk),
    .reset  (reset),
    .iLevel (iStart),
    .oPulse (startRise)
  );

  assign lastAddr = (cnt == 8'(NBYTES - 1));
  assign timeUp   = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE, DONE: if (startRise) stateNext = REQ;
      REQ:        stateNext = RECV;
      RECV: begin
        if (iByteValid) begin
          if (lastAddr) stateNext = DONE;
        end else if (timeUp) begin
          stateNext = PAD;
        end
      end
      PAD:        if (lastAddr) stateNext = DONE;
      default:    stateNext = IDLE;
    endcase
  end

  // A byte on the timeout cycle wins: the
  // timeout branch is only taken without one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oReq    <= 1'b0;
      oWrAddr <= 8'd0;
      oWrData <= 8'd0;
      oWren   <= 1'b0;
      oDone   <= 1'b0;
      oErr    <= 1'b0;
      cnt     <= 8'd0;
      timer   <= '0;
    end else begin
      oReq  <= (state == REQ);
      oWren <= 1'b0;
      oDone <= (state == DONE) && !startRise;
      unique case (state)
        IDLE, DONE: begin
          if (startRise) begin
            oErr  <= 1'b0;
            cnt   <= 8'd0;
            timer <= '0;
          end
        end
        RECV: begin
          if (iByteValid) begin
            oWren   <= 1'b1;
            oWrAddr <= cnt;
            oWrData <= iByte;
            cnt     <= cnt + 8'd1;
            timer   <= '0;
          end else if (timeUp) begin
            oErr <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PAD: begin
          oWren   <= 1'b1;
          oWrAddr <= cnt;
          oWrData <= 8'h00;
          cnt     <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcm_collect.sv
// Scoreboard bench for mcm_collect with a short gap timeout.
// Expected RAM writes are queued as stimulus is driven.
module tb_mcm_collect;

  localparam int NB = 144;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       iStart = 1'b0;
  logic [7:0] iByte = 8'd0;
  logic       iByteValid = 1'b0;
  logic       oReq;
  logic [7:0] oWrAddr;
  logic [7:0] oWrData;
  logic       oWren;
  logic       oDone;
  logic       oErr;

  int checks = 0;
  int failures = 0;
  int reqCount = 0;
  int wrCount = 0;
  logic [15:0] expQ[$];
  logic [7:0]  expAddr = 8'd0;
  logic [7:0]  mem [256];

  always #5 clk = ~clk;

  mcm_collect #(.NBYTES(NB), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .iStart     (iStart),
    .iByte      (iByte),
    .iByteValid (iByteValid),
    .oReq       (oReq),
    .oWrAddr    (oWrAddr),
    .oWrData    (oWrData),
    .oWren      (oWren),
    .oDone      (oDone),
    .oErr       (oErr)
  );

  always @(negedge clk) begin
    if (oReq) reqCount++;
    if (oWren) begin
      logic [15:0] e;
      wrCount++;
      mem[oWrAddr] = oWrData;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected addr=%0d data=%h required none",
                 oWrAddr, oWrData);
      end else begin
        e = expQ.pop_front();
        if ({oWrAddr, oWrData} !== e) begin
          failures++;
          $display("FAIL write_seq got addr=%0d data=%h required addr=%0d data=%h",
                   oWrAddr, oWrData, e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    iByte = b;
    iByteValid = 1'b1;
    expQ.push_back({expAddr, b});
    expAddr++;
    tick();
    iByteValid = 1'b0;
  endtask

  task automatic startFrame();
    iStart = 1'b1;
    expAddr = 8'd0;
    idle(5);
    iStart = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!oDone && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (oDone !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout got oDone=%b required 1", name, oDone);
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes got %0d pending required 0",
               name, expQ.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({oReq, oWren, oDone, oErr, oWrAddr, oWrData} !== 20'd0) begin
      failures++;
      $display("FAIL reset_outputs got %b%b%b%b %h %h required all 0",
               oReq, oWren, oDone, oErr, oWrAddr, oWrData);
    end
    idle(3);
    reset = 1'b1;
    idle(2);
    iByte = 8'h77;
    iByteValid = 1'b1;
    idle(3);
    iByteValid = 1'b0;
    idle(2);
    checks++;
    if (wrCount != 0 || oDone !== 1'b0) begin
      failures++;
      $display("FAIL idle_stray got writes=%0d oDone=%b required 0 0",
               wrCount, oDone);
    end
  endtask

  task automatic test_full_frame();
    int r0 = reqCount;
    int w0 = wrCount;
    int bad = 0;
    startFrame();
    checks++;
    if (reqCount != r0 + 1) begin
      failures++;
      $display("FAIL full_req got %0d required 1", reqCount - r0);
    end
    for (int i = 0; i < NB; i++) begin
      sendByte(8'(i));
      if (i != NB - 1) idle(4);
    end
    checks++;
    if (oDone !== 1'b0) begin
      failures++;
      $display("FAIL full_done_early got %b required 0", oDone);
    end
    tick();
    checks++;
    if (oDone !== 1'b1 || oErr !== 1'b0) begin
      failures++;
      $display("FAIL full_done_err got done=%b err=%b required 1 0",
               oDone, oErr);
    end
    for (int i = 0; i < NB; i++)
      if (mem[i] !== 8'(i)) bad++;
    checks++;
    if (bad != 0 || wrCount != w0 + NB) begin
      failures++;
      $display("FAIL full_ram got bad=%0d writes=%0d required 0 %0d",
               bad, wrCount - w0, NB);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int bad = 0;
    startFrame();
    for (int i = 0; i < 100; i++) sendByte(8'(i + 1));
    for (int i = 100; i < NB; i++) expQ.push_back({8'(i), 8'h00});
    while (!oErr && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (oErr !== 1'b1 || n != TO) begin
      failures++;
      $display("FAIL timeout_gap got err=%b cycles=%0d required 1 %0d",
               oErr, n, TO);
    end
    for (int i = 100; i < NB; i++) begin
      tick();
      if (oWren !== 1'b1 || oWrAddr !== 8'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL pad_consecutive got %0d gaps required 0", bad);
    end
    tick();
    checks++;
    if (oDone !== 1'b1 || oErr !== 1'b1 || oWren !== 1'b0) begin
      failures++;
      $display("FAIL pad_done got done=%b err=%b wren=%b required 1 1 0",
               oDone, oErr, oWren);
    end
    waitDone("timeout");
  endtask

  task automatic test_restart();
    int bad = 0;
    iStart = 1'b1;
    expAddr = 8'd0;
    idle(2);
    checks++;
    if (oDone !== 1'b1) begin
      failures++;
      $display("FAIL restart_k1 got oDone=%b required 1", oDone);
    end
    tick();
    checks++;
    if (oDone !== 1'b0 || oErr !== 1'b0 || oReq !== 1'b0) begin
      failures++;
      $display("FAIL restart_k2 got done=%b err=%b req=%b required 0 0 0",
               oDone, oErr, oReq);
    end
    tick();
    checks++;
    if (oReq !== 1'b1) begin
      failures++;
      $display("FAIL restart_k3 got oReq=%b required 1", oReq);
    end
    tick();
    checks++;
    if (oReq !== 1'b0) begin
      failures++;
      $display("FAIL restart_k4 got oReq=%b required 0", oReq);
    end
    iStart = 1'b0;
    for (int i = 0; i < NB; i++) begin
      sendByte(8'hA5);
      idle(1);
    end
    waitDone("restart");
    for (int i = 0; i < NB; i++)
      if (mem[i] !== 8'hA5) bad++;
    checks++;
    if (bad != 0 || oErr !== 1'b0) begin
      failures++;
      $display("FAIL restart_ram got bad=%0d err=%b required 0 0", bad, oErr);
    end
  endtask

  task automatic test_stray();
    int r0 = reqCount;
    int w0 = wrCount;
    iByte = 8'hEE;
    iByteValid = 1'b1;
    idle(3);
    iByteValid = 1'b0;
    idle(2);
    checks++;
    if (wrCount != w0) begin
      failures++;
      $display("FAIL done_stray got %0d writes required 0", wrCount - w0);
    end
    startFrame();
    for (int i = 0; i < NB; i++) begin
      if (i == 20) iStart = 1'b1;
      if (i == 30) iStart = 1'b0;
      sendByte(8'(i) ^ 8'h3C);
    end
    waitDone("stray");
    idle(3);
    checks++;
    if (reqCount != r0 + 1 || wrCount != w0 + NB) begin
      failures++;
      $display("FAIL stray_frame got req=%0d writes=%0d required 1 %0d",
               reqCount - r0, wrCount - w0, NB);
    end
  endtask

  task automatic test_byte_wins();
    int errSeen = 0;
    startFrame();
    idle(TO - 2);
    sendByte(8'h11);
    for (int j = 0; j < 4; j++) begin
      idle(TO - 1);
      sendByte(8'(8'h20 + j));
      if (oErr !== 1'b0) errSeen++;
    end
    for (int i = 5; i < NB; i++) sendByte(8'(i));
    waitDone("edge");
    checks++;
    if (errSeen != 0 || oErr !== 1'b0) begin
      failures++;
      $display("FAIL byte_wins_err got err=%b seen=%0d required 0 0",
               oErr, errSeen);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    startFrame();
    for (int i = 0; i < 50; i++) sendByte(8'(i + 7));
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({oReq, oWren, oDone, oErr, oWrAddr, oWrData} !== 20'd0) begin
      failures++;
      $display("FAIL midreset_outputs got %b%b%b%b %h %h required all 0",
               oReq, oWren, oDone, oErr, oWrAddr, oWrData);
    end
    expQ.delete();
    idle(3);
    reset = 1'b1;
    idle(2);
    w0 = wrCount;
    startFrame();
    checks++;
    if (oDone !== 1'b0) begin
      failures++;
      $display("FAIL midreset_done got %b required 0", oDone);
    end
    for (int i = 0; i < NB; i++) sendByte(8'(NB - i));
    waitDone("midreset");
    checks++;
    if (wrCount != w0 + NB) begin
      failures++;
      $display("FAIL midreset_count got %0d required %0d",
               wrCount - w0, NB);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_timeout();
    test_restart();
    test_stray();
    test_byte_wins();
    test_reset_mid();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
